// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day core and the display driver.
package clock_pkg;

  typedef enum logic [1:0] {
    SETUP   = 2'b00,
    TIME24  = 2'b01,
    SECONDS = 2'b10,
    TIME12  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FIRSTDIGIT  = 2'd0,
    SECONDDIGIT = 2'd1,
    THIRDDIGIT  = 2'd2,
    FOURTHDIGIT = 2'd3
  } location_e;

  localparam logic [3:0] MAX_NINE  = 4'd9;
  localparam logic [3:0] MAX_FIVE  = 4'd5;
  localparam logic [3:0] MAX_TWO   = 4'd2;
  localparam logic [3:0] MAX_THREE = 4'd3;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      TIME24:  return SECONDS;
      SECONDS: return TIME12;
      TIME12:  return SETUP;
      default: return TIME24;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counter: wraps at MAX, load overrides increment.
module bcd_digit
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX = MAX_NINE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] q_o,
  output logic       co_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)      cnt_d = ld_val_i;
    else if (en_i) cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q_o  = cnt_q;
  assign co_o = en_i && (cnt_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day core with 1 Hz prescaler, blink divider,
// display mode sequencing and setup-digit editing.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       modeBtn,
  input  logic       nextBtn,
  input  logic       incBtn,
  output logic [1:0] mode,
  output logic [1:0] location,
  output logic [3:0] hoursUpper,
  output logic [3:0] hoursLower,
  output logic [3:0] minutesUpper,
  output logic [3:0] minutesLower,
  output logic [3:0] secondsUpper,
  output logic [3:0] secondsLower,
  output logic       pm,
  output logic       blink,
  output logic       tick1Hz
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] BLK_TC = PW'(CLK_HZ / 2 - 1);

  mode_e         mode_q, mode_d;
  location_e     loc_q, loc_d;
  logic [PW-1:0] pre_q, pre_d, blk_q, blk_d;
  logic          blink_q, blink_d, tick_q;
  logic          run, tick, enter_setup, next_act, inc_act;

  assign run         = (mode_q != SETUP);
  assign tick        = run && (pre_q == PRE_TC);
  assign enter_setup = modeBtn && (next_mode(mode_q) == SETUP);
  assign next_act    = nextBtn && !modeBtn && !run;
  assign inc_act     = incBtn && !modeBtn && !nextBtn && !run;

  always_comb begin
    mode_d  = mode_q;
    loc_d   = loc_q;
    pre_d   = pre_q;
    blk_d   = blk_q;
    blink_d = blink_q;
    if (modeBtn) begin
      mode_d = next_mode(mode_q);
      if (mode_d == SETUP) loc_d = FIRSTDIGIT;
    end else if (next_act) begin
      loc_d = location_e'(loc_q + 2'd1);
    end
    if (!run || enter_setup || tick) pre_d = '0;
    else                             pre_d = pre_q + 1'b1;
    if (blk_q == BLK_TC) begin
      blk_d   = '0;
      blink_d = ~blink_q;
    end else begin
      blk_d = blk_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= TIME24;
      loc_q   <= FIRSTDIGIT;
      pre_q   <= '0;
      blk_q   <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      loc_q   <= loc_d;
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      blink_q <= blink_d;
      tick_q  <= tick;
    end
  end

  logic [3:0] sl, su, ml, mu, hl, hu;
  logic       sl_co, su_co, ml_co, mu_co, hl_co, hu_co_unused;
  logic       inc_hu, inc_hl, inc_mu, inc_ml;
  logic       day_wrap, hl_wrap_set, hl_clamp;

  assign inc_hu = inc_act && (loc_q == FIRSTDIGIT);
  assign inc_hl = inc_act && (loc_q == SECONDDIGIT);
  assign inc_mu = inc_act && (loc_q == THIRDDIGIT);
  assign inc_ml = inc_act && (loc_q == FOURTHDIGIT);

  // Carries only count on a tick; setup increments must not ripple.
  assign day_wrap    = tick && mu_co && (hu == MAX_TWO) && (hl == MAX_THREE);
  assign hl_wrap_set = inc_hl && (hu == MAX_TWO) && (hl == MAX_THREE);
  assign hl_clamp    = inc_hu && (hu == 4'd1) && (hl > MAX_THREE);

  bcd_digit #(.MAX(MAX_NINE)) u_sl (
    .clk(clk), .rst_n(rst_n), .en_i(tick), .ld_i(enter_setup), .ld_val_i('0),
    .q_o(sl), .co_o(sl_co));
  bcd_digit #(.MAX(MAX_FIVE)) u_su (
    .clk(clk), .rst_n(rst_n), .en_i(sl_co), .ld_i(enter_setup), .ld_val_i('0),
    .q_o(su), .co_o(su_co));
  bcd_digit #(.MAX(MAX_NINE)) u_ml (
    .clk(clk), .rst_n(rst_n), .en_i(su_co || inc_ml), .ld_i(1'b0), .ld_val_i('0),
    .q_o(ml), .co_o(ml_co));
  bcd_digit #(.MAX(MAX_FIVE)) u_mu (
    .clk(clk), .rst_n(rst_n), .en_i((ml_co && tick) || inc_mu), .ld_i(1'b0), .ld_val_i('0),
    .q_o(mu), .co_o(mu_co));
  bcd_digit #(.MAX(MAX_NINE)) u_hl (
    .clk(clk), .rst_n(rst_n), .en_i((mu_co && tick) || inc_hl),
    .ld_i(day_wrap || hl_wrap_set || hl_clamp), .ld_val_i(hl_clamp ? MAX_THREE : 4'd0),
    .q_o(hl), .co_o(hl_co));
  bcd_digit #(.MAX(MAX_TWO)) u_hu (
    .clk(clk), .rst_n(rst_n), .en_i((hl_co && tick) || inc_hu), .ld_i(day_wrap), .ld_val_i('0),
    .q_o(hu), .co_o(hu_co_unused));

  assign mode         = mode_q;
  assign location     = loc_q;
  assign hoursUpper   = hu;
  assign hoursLower   = hl;
  assign minutesUpper = mu;
  assign minutesLower = ml;
  assign secondsUpper = su;
  assign secondsLower = sl;
  assign pm           = (hu == MAX_TWO) || ((hu == 4'd1) && (hl >= 4'd2));
  assign blink        = blink_q;
  assign tick1Hz      = tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       modeBtn = 1'b0, nextBtn = 1'b0, incBtn = 1'b0;
  logic [1:0] mode, location;
  logic [3:0] hoursUpper, hoursLower, minutesUpper, minutesLower, secondsUpper, secondsLower;
  logic       pm, blink, tick1Hz;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .modeBtn(modeBtn), .nextBtn(nextBtn), .incBtn(incBtn),
    .mode(mode), .location(location),
    .hoursUpper(hoursUpper), .hoursLower(hoursLower),
    .minutesUpper(minutesUpper), .minutesLower(minutesLower),
    .secondsUpper(secondsUpper), .secondsLower(secondsLower),
    .pm(pm), .blink(blink), .tick1Hz(tick1Hz));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: time as seconds since midnight; mode codes 0=SETUP 1=TIME24 2=SECONDS 3=TIME12
  int m_tod, m_mode, m_loc, m_pcnt, m_bcnt, m_blink, m_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bcd_of(input int tod);
    int h, m, s;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int model_digit(input int loc);
    int h, m;
    h = m_tod / 3600; m = (m_tod / 60) % 60;
    case (loc)
      0: return h / 10;
      1: return h % 10;
      2: return m / 10;
      default: return m % 10;
    endcase
  endfunction

  task automatic model_reset();
    m_tod = 0; m_mode = 1; m_loc = 0; m_pcnt = 0; m_bcnt = 0; m_blink = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit mb, input bit nb, input bit ib);
    int h, m, s, hu, hl, mu, ml;
    m_tick = (m_mode != 0 && m_pcnt == CLK_HZ - 1) ? 1 : 0;
    if (m_tick == 1) begin
      m_tod = (m_tod + 1) % 86400;
      m_pcnt = 0;
    end else if (m_mode != 0) begin
      m_pcnt++;
    end
    if (m_bcnt == CLK_HZ / 2 - 1) begin
      m_bcnt = 0; m_blink = 1 - m_blink;
    end else begin
      m_bcnt++;
    end
    if (mb) begin
      case (m_mode)
        1: m_mode = 2;
        2: m_mode = 3;
        3: m_mode = 0;
        default: m_mode = 1;
      endcase
      if (m_mode == 0) begin
        m_loc = 0; m_tod = m_tod - (m_tod % 60); m_pcnt = 0;
      end
    end else if (m_mode == 0 && nb) begin
      m_loc = (m_loc + 1) % 4;
    end else if (m_mode == 0 && ib) begin
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      hu = h / 10; hl = h % 10; mu = m / 10; ml = m % 10;
      case (m_loc)
        0: begin hu = (hu + 1) % 3; if (hu == 2 && hl > 3) hl = 3; end
        1: hl = (hu == 2) ? (hl + 1) % 4 : (hl + 1) % 10;
        2: mu = (mu + 1) % 6;
        default: ml = (ml + 1) % 10;
      endcase
      m_tod = (hu * 10 + hl) * 3600 + (mu * 10 + ml) * 60 + s;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".time"}, {8'h0, hoursUpper, hoursLower, minutesUpper, minutesLower,
                              secondsUpper, secondsLower}, {8'h0, bcd_of(m_tod)});
    check_eq({tag, ".mode"}, mode, m_mode);
    check_eq({tag, ".loc"}, location, m_loc);
    check_eq({tag, ".pm"}, pm, (m_tod / 3600 >= 12) ? 1 : 0);
    check_eq({tag, ".blink"}, blink, m_blink);
    check_eq({tag, ".tick"}, tick1Hz, m_tick);
  endtask

  // Called from posedge+1; drives inputs for the next edge, then checks after it.
  task automatic step_cycle(input bit mb, input bit nb, input bit ib);
    modeBtn = mb; nextBtn = nb; incBtn = ib;
    @(posedge clk);
    model_step(mb, nb, ib);
    #1;
    modeBtn = 1'b0; nextBtn = 1'b0; incBtn = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 4 && m_mode != target; k++) step_cycle(1, 0, 0);
  endtask

  task automatic set_time(input int thu, input int thl, input int tmu, input int tml);
    int tgt[4];
    tgt[0] = thu; tgt[1] = thl; tgt[2] = tmu; tgt[3] = tml;
    goto_mode(0);
    for (int loc = 0; loc < 4; loc++) begin
      for (int k = 0; k < 10 && model_digit(loc) != tgt[loc]; k++) step_cycle(0, 0, 1);
      step_cycle(0, 1, 0);
    end
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // First tick lands on the tenth edge after release.
    repeat (12) step_cycle(0, 0, 0);

    // Day rollover from 23:59:xx
    set_time(2, 3, 5, 9);
    goto_mode(1);
    check_eq("rollover.pm_before", pm, 1);
    repeat (60 * CLK_HZ + 5) step_cycle(0, 0, 0);

    // Carry chain 09:59:59 -> 10:00:00
    set_time(0, 9, 5, 9);
    goto_mode(1);
    repeat (60 * CLK_HZ + 5) step_cycle(0, 0, 0);

    // Setup edit with hoursLower clamp
    set_time(1, 7, 0, 0);
    step_cycle(0, 0, 1);
    check_eq("clamp.hu", hoursUpper, 2);
    check_eq("clamp.hl", hoursLower, 3);
    repeat (4) step_cycle(0, 1, 0);
    check_eq("loc.wrap", location, 0);
    step_cycle(1, 0, 1);
    check_eq("simul.mode", mode, 1);
    step_cycle(0, 0, 1);
    step_cycle(0, 1, 1);

    // Async reset mid-prescaler at 12:34:56
    set_time(1, 2, 3, 4);
    goto_mode(1);
    for (int k = 0; k < 80 * CLK_HZ && (m_tod % 60) != 56; k++) step_cycle(0, 0, 0);
    check_eq("async.reach56", m_tod % 60, 56);
    repeat (3) step_cycle(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async");
    @(posedge clk);
    #1;
    check_outputs("inrst");
    rst_n = 1'b1;
    repeat (25) step_cycle(0, 0, 0);

    // Random buttons
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 31));
      if (r == 10)     step_cycle(1, 1, 1);
      else if (r == 11) step_cycle(0, 1, 1);
      else              step_cycle(r == 0, r >= 1 && r <= 3, r >= 4 && r <= 9);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
